lc_state_encoder: RTL
=====================

# lc_state_encoder

Transition-side counterpart of the lifecycle state decoder. It accepts a decoded current state and a decoded target state (both `dec_lc_state_e`, 5 bits) and validates the pair. It then programs the encoded lifecycle words that differ between the two states into OTP through a word-serial valid/ready write port, and reports completion or an error code. It sits between the lifecycle transition FSM and the OTP program interface.

## Interface
Parameters:
- `NumWords`, 20: number of encoded lifecycle words.
- `WordW`, 16: OTP word width.
- `MarkWord`, 16'hA5C3: base pattern for a programmed word.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  transition request valid.
- `req_ready_o`  out  1  request accepted when valid && ready.
- `cur_state_i`  in  5  current decoded state (`dec_lc_state_e`).
- `tgt_state_i`  in  5  target decoded state (`dec_lc_state_e`).
- `otp_valid_o`  out  1  write word valid.
- `otp_ready_i`  in  1  OTP accepts word.
- `otp_addr_o`  out  $clog2(NumWords)  word index.
- `otp_data_o`  out  WordW  word value.
- `otp_err_i`  in  1  write failure; sampled only on OTP handshake.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  error flag, valid only with `done_o`.
- `err_code_o`  out  2  error code: 0 none, 1 illegal state, 2 non-forward, 3 OTP fail; valid only with `done_o`.

## Operation
- Encoding: state value n (TestUnlocked0=1 … Scrap=20) means words 0..n-1 are programmed and the rest are 0.
  - Programmed word i = `MarkWord ^ zero-extend(i)`.
  - Raw (0) means no words are programmed.
- Legal states for both `cur` and `tgt` are 0..20. PostTrans, Escalate and Invalid (21..23) are illegal.
  - `tgt` = 0 is also illegal.
  - An illegal state gives error code 1.
- The transition must move forward: `tgt` > `cur`. Otherwise the block reports error code 2 and performs no OTP writes.
  - Code 1 takes priority over code 2.
- The block writes exactly addresses `cur`..`tgt`-1, in ascending order. It never writes other addresses.
- FSM states: IDLE, CHECK, WRITE, DONE.
  - IDLE: `req_ready_o`=1. On accept, register `cur` and `tgt`, then go to CHECK.
  - CHECK: one cycle. On error, latch the code and go to DONE. Otherwise set addr=`cur` and go to WRITE.
  - WRITE: `otp_valid_o`=1 with addr and data stable until handshake. On handshake:
    - if `otp_err_i`, code 3, go to DONE (abort, no further words);
    - else if addr=`tgt`-1, go to DONE;
    - else addr+1 and stay in WRITE.
  - DONE: `done_o`=1 for one cycle, then go to IDLE.
- Inputs other than `otp_*` are ignored outside IDLE.

## Timing
- Reset values: `req_ready_o`=1 (IDLE), `otp_valid_o`=0, `otp_addr_o`=0, `otp_data_o`=0, `done_o`=0, `err_o`=0, `err_code_o`=0.
- Accept at cycle 0 → CHECK at cycle 1 → first `otp_valid_o` at cycle 2.
  - On an error found in CHECK, `done_o` is asserted at cycle 2.
- With `otp_ready_i` tied to 1, one word is written per cycle, back to back.
  - For k words: `done_o` at cycle 2+k, `req_ready_o` again at cycle 3+k.
- Backpressure: while `otp_ready_i`=0, all `otp_*` outputs hold.
- `otp_err_i` on the last word still gives code 3.
- Reset mid-operation: the next edge forces IDLE and the reset values. The write sequence is dropped with no `done_o` and no resume.
- Address arithmetic is 5-bit. `tgt`≤20 keeps addr ≤19, so addr never wraps.

## Structure
- Package `lc_enc_pkg` holds:
  - `dec_lc_state_e` (24 values, 5 bits, DecLcStRaw=0 … DecLcStInvalid=23);
  - `NumLcWords`, `LcWordW`, `LcMarkWord`;
  - the error-code enum `lc_enc_err_e`;
  - the FSM state enum.
- One combinational sub-module, `lc_target_check`: takes (cur, tgt) and outputs (ok, err_code).
- The data path (address counter, word XOR) stays in the top.

## Test plan
- cur=DecLcStTestLocked4 (10), tgt=DecLcStDev (16), ready=1 → addrs 10..15 on consecutive cycles; data 16'hA5C9, A5C8, A5CF, A5CE, A5CD, A5CC; `done_o` at cycle 8 with `err_o`=0.
- cur=Raw (0), tgt=TestUnlocked0 (1) → single write: addr 0, data 16'hA5C3; `done_o` at cycle 3.
- cur=16, tgt=10 → error code 2 at cycle 2, no OTP write. Then tgt=23 with any cur → code 1, no write.
- cur=18, tgt=20, `otp_ready_i` low for 3 cycles on the first word → addr 18 and data 16'hA5D1 held stable, then addr 19 with data 16'hA5D0.
- cur=0, tgt=5, `otp_err_i`=1 on the handshake of addr 2 → no write to addr 3, `done_o` with code 3.
- Reset asserted during WRITE at addr 12 (cur=10, tgt=16) → next cycle `otp_valid_o`=0, `req_ready_o`=1, no `done_o`. A new request then runs normally.

Source files
------------

// File: rtl/lc_enc_pkg.sv
// lc_enc_pkg: shared types and constants for the lifecycle state encoder.
package lc_enc_pkg;
  localparam int NumLcWords = 20;
  localparam int LcWordW = 16;
  localparam logic [15:0] LcMarkWord = 16'hA5C3;
  typedef enum logic [4:0] {
    DecLcStRaw           = 5'd0,
    DecLcStTestUnlocked0 = 5'd1,
    DecLcStTestLocked0   = 5'd2,
    DecLcStTestUnlocked1 = 5'd3,
    DecLcStTestLocked1   = 5'd4,
    DecLcStTestUnlocked2 = 5'd5,
    DecLcStTestLocked2   = 5'd6,
    DecLcStTestUnlocked3 = 5'd7,
    DecLcStTestLocked3   = 5'd8,
    DecLcStTestUnlocked4 = 5'd9,
    DecLcStTestLocked4   = 5'd10,
    DecLcStTestUnlocked5 = 5'd11,
    DecLcStTestLocked5   = 5'd12,
    DecLcStTestUnlocked6 = 5'd13,
    DecLcStTestLocked6   = 5'd14,
    DecLcStTestUnlocked7 = 5'd15,
    DecLcStDev           = 5'd16,
    DecLcStProd          = 5'd17,
    DecLcStProdEnd       = 5'd18,
    DecLcStRma           = 5'd19,
    DecLcStScrap         = 5'd20,
    DecLcStPostTrans     = 5'd21,
    DecLcStEscalate      = 5'd22,
    DecLcStInvalid       = 5'd23
  } dec_lc_state_e;
  typedef enum logic [1:0] {ErrNone, ErrIllegal, ErrNonFwd, ErrOtp} lc_enc_err_e;
  typedef enum logic [1:0] {StIdle, StCheck, StWrite, StDone} lc_enc_st_e;
endpackage

// File: rtl/lc_state_encoder_check.sv
// lc_target_check: validates a (current, target) lifecycle pair.
module lc_target_check
  import lc_enc_pkg::*;
(
  input  logic [4:0]  cur,
  input  logic [4:0]  tgt,
  output logic        ok,
  output lc_enc_err_e err_code
);
  logic illegal;
  assign illegal = cur > DecLcStScrap || tgt > DecLcStScrap || tgt == DecLcStRaw;
  assign err_code = illegal ? ErrIllegal : (tgt <= cur) ? ErrNonFwd : ErrNone;
  assign ok = err_code == ErrNone;
endmodule

// File: rtl/lc_state_encoder.sv
// lc_state_encoder: programs the OTP words that differ between two lifecycle states.
module lc_state_encoder
  import lc_enc_pkg::*;
#(
  parameter int NumWords = NumLcWords,
  parameter int WordW = LcWordW,
  parameter logic [WordW-1:0] MarkWord = WordW'(LcMarkWord)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [4:0]                  cur_state_i,
  input  logic [4:0]                  tgt_state_i,
  output logic                        otp_valid_o,
  input  logic                        otp_ready_i,
  output logic [$clog2(NumWords)-1:0] otp_addr_o,
  output logic [WordW-1:0]            otp_data_o,
  input  logic                        otp_err_i,
  output logic                        done_o,
  output logic                        err_o,
  output logic [1:0]                  err_code_o
);
  localparam int AddrW = $clog2(NumWords);
  lc_enc_st_e state_q, state_d;
  lc_enc_err_e code_q, code_d, chk_code;
  logic [4:0] cur_q, cur_d, tgt_q, tgt_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic chk_ok, last;
  lc_target_check u_check (
    .cur      (cur_q),
    .tgt      (tgt_q),
    .ok       (chk_ok),
    .err_code (chk_code)
  );
  assign last = 5'(addr_q) == tgt_q - 5'd1;
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    cur_d = cur_q;
    tgt_d = tgt_q;
    addr_d = addr_q;
    case (state_q)
      StIdle: if (req_valid_i) begin
        cur_d = cur_state_i;
        tgt_d = tgt_state_i;
        code_d = ErrNone;
        state_d = StCheck;
      end
      StCheck: if (!chk_ok) begin
        code_d = chk_code;
        state_d = StDone;
      end else begin
        addr_d = AddrW'(cur_q);
        state_d = StWrite;
      end
      StWrite: if (otp_ready_i) begin
        code_d = otp_err_i ? ErrOtp : code_q;
        state_d = (otp_err_i || last) ? StDone : StWrite;
        addr_d = (otp_err_i || last) ? addr_q : addr_q + AddrW'(1);
      end
      default: state_d = StIdle;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      code_q <= ErrNone;
      cur_q <= '0;
      tgt_q <= '0;
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      cur_q <= cur_d;
      tgt_q <= tgt_d;
      addr_q <= addr_d;
    end
  end
  assign req_ready_o = state_q == StIdle;
  assign otp_valid_o = state_q == StWrite;
  assign otp_addr_o = addr_q;
  // Data is only driven while a word is offered so the idle bus reads as zero.
  assign otp_data_o = otp_valid_o ? MarkWord ^ WordW'(addr_q) : '0;
  assign done_o = state_q == StDone;
  assign err_code_o = done_o ? code_q : ErrNone;
  assign err_o = done_o && code_q != ErrNone;
endmodule
